// File: rtl/maxis_vpg_pkg.sv
// Shared types and helpers for the maxis_vpattern_gen video test-pattern master.
package maxis_vpg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FGAP = 2'd1,
    LGAP = 2'd2,
    SEND = 2'd3
  } state_e;

  localparam logic [1:0] MODE_COUNTER = 2'd0;
  localparam logic [1:0] MODE_BARS    = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_CONST   = 2'd3;

  // Bits needed to index 0..n-1, never less than one.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/maxis_vpg_pixel.sv
// Combinational pattern function for one pixel at column p of line y.
module maxis_vpg_pixel
  import maxis_vpg_pkg::*;
#(
  parameter int unsigned BITS_PER_PIXEL    = 8,
  parameter int unsigned PIXELS_HORIZONTAL = 1280,
  parameter int unsigned XW                = 11,
  parameter int unsigned YW                = 10,
  parameter int unsigned FCW               = 4
) (
  input  logic [1:0]                mode_i,
  input  logic [XW-1:0]             p_i,
  input  logic [YW-1:0]             y_i,
  input  logic [FCW-1:0]            frame_cnt_i,
  output logic [BITS_PER_PIXEL-1:0] pixel_c
);

  localparam int unsigned BW = XW + 3;

  logic [BW-1:0] p_x8;
  logic [BW-1:0] bar;
  logic [2:0]    bar3;
  logic          chk;

  always_comb begin
    p_x8    = {p_i, 3'b000};
    bar     = p_x8 / BW'(PIXELS_HORIZONTAL);
    bar3    = 3'(bar);
    // Bit 3 of p and y selects the 8x8 checker square.
    chk     = (|(p_i & XW'(8))) ^ (|(y_i & YW'(8)));
    pixel_c = '0;
    case (mode_i)
      MODE_COUNTER: pixel_c = BITS_PER_PIXEL'(p_i) + BITS_PER_PIXEL'(y_i)
                              + BITS_PER_PIXEL'(frame_cnt_i);
      MODE_BARS:    pixel_c = BITS_PER_PIXEL'(bar3) << (BITS_PER_PIXEL - 3);
      MODE_CHECKER: pixel_c = {BITS_PER_PIXEL{chk}};
      default:      pixel_c = '1;
    endcase
  end

endmodule

// File: rtl/maxis_vpattern_gen.sv
// AXI4-Stream video test-pattern master: frames of lines with line/frame blanking.
// Optional stall counter built when MAXIS_VPG_STALL_CNT_EN is defined.
module maxis_vpattern_gen
  import maxis_vpg_pkg::*;
#(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned BITS_PER_PIXEL       = 8,
  parameter int unsigned PIXELS_HORIZONTAL    = 1280,
  parameter int unsigned PIXELS_VERTICAL      = 1024,
  parameter int unsigned LINE_GAP             = 3,
  parameter int unsigned FRAME_GAP            = 10000,
  parameter int unsigned FRAME_CNT_WIDTH      = 4
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESET,
  input  logic                              enable,
  input  logic [1:0]                        mode,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TUSER,
  input  logic                              M_AXIS_TREADY,
  output logic [FRAME_CNT_WIDTH-1:0]        frame_cnt,
  output logic                              frame_done,
  output logic [31:0]                       stall_cnt
);

  localparam int unsigned PPB      = C_M_AXIS_TDATA_WIDTH / BITS_PER_PIXEL;
  localparam int unsigned XW       = cw(PIXELS_HORIZONTAL);
  localparam int unsigned YW       = cw(PIXELS_VERTICAL);
  localparam int unsigned GAP_MAX  = (FRAME_GAP > LINE_GAP) ? FRAME_GAP : LINE_GAP;
  localparam int unsigned GW       = cw(GAP_MAX + 1);
  localparam int unsigned LGAP_TOP = (LINE_GAP > 0) ? LINE_GAP - 1 : 0;

  localparam logic [XW-1:0] X_LAST   = XW'(PIXELS_HORIZONTAL - PPB);
  localparam logic [XW-1:0] X_STEP   = XW'(PPB);
  localparam logic [YW-1:0] Y_LAST   = YW'(PIXELS_VERTICAL - 1);
  localparam logic [GW-1:0] FGAP_END = GW'(FRAME_GAP);
  localparam logic [GW-1:0] LGAP_END = GW'(LGAP_TOP);

  state_e                            state_q, state_d;
  logic [XW-1:0]                     x_q, x_d;
  logic [YW-1:0]                     y_q, y_d;
  logic [1:0]                        mode_q, mode_d;
  logic [GW-1:0]                     gap_q, gap_d;
  logic [FRAME_CNT_WIDTH-1:0]        frame_cnt_q, frame_cnt_d;
  logic                              frame_done_q, frame_done_d;
  logic                              tvalid_q, tvalid_d;
  logic                              tlast_q, tlast_d;
  logic                              tuser_q, tuser_d;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [PPB-1:0][BITS_PER_PIXEL-1:0] pix_c;
  logic                              hs_c;

  assign hs_c = tvalid_q & M_AXIS_TREADY;

  // Next state, beat position and frame bookkeeping.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    mode_d       = mode_q;
    gap_d        = gap_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = FGAP;
          gap_d   = '0;
        end
      end
      FGAP: begin
        if (gap_q == FGAP_END) begin
          state_d = SEND;
          x_d     = '0;
          y_d     = '0;
          mode_d  = mode;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      LGAP: begin
        if (gap_q == LGAP_END) state_d = SEND;
        else                   gap_d   = gap_q + GW'(1);
      end
      SEND: begin
        if (hs_c) begin
          if (x_q != X_LAST) begin
            x_d = x_q + X_STEP;
          end else if (y_q != Y_LAST) begin
            x_d     = '0;
            y_d     = y_q + YW'(1);
            gap_d   = '0;
            state_d = (LINE_GAP == 0) ? SEND : LGAP;
          end else begin
            frame_cnt_d  = frame_cnt_q + FRAME_CNT_WIDTH'(1);
            frame_done_d = 1'b1;
            gap_d        = '0;
            state_d      = enable ? FGAP : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tvalid_d = (state_d == SEND);
    tlast_d  = tvalid_d && (x_d == X_LAST);
    tuser_d  = tvalid_d && (x_d == '0) && (y_d == '0);
  end

  // Pixels for the beat that will be presented after this edge.
  for (genvar i = 0; i < PPB; i++) begin : g_pix
    logic [XW-1:0] p_c;
    assign p_c = x_d + XW'(i);
    maxis_vpg_pixel #(
      .BITS_PER_PIXEL   (BITS_PER_PIXEL),
      .PIXELS_HORIZONTAL(PIXELS_HORIZONTAL),
      .XW               (XW),
      .YW               (YW),
      .FCW              (FRAME_CNT_WIDTH)
    ) u_pixel (
      .mode_i     (mode_d),
      .p_i        (p_c),
      .y_i        (y_d),
      .frame_cnt_i(frame_cnt_d),
      .pixel_c    (pix_c[i])
    );
  end

  always_comb begin
    tdata_d = '0;
    if (tvalid_d) tdata_d = pix_c;
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      mode_q       <= MODE_COUNTER;
      gap_q        <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      tdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      mode_q       <= mode_d;
      gap_q        <= gap_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      tdata_q      <= tdata_d;
    end
  end

`ifdef MAXIS_VPG_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of offered-but-not-accepted cycles, cleared at frame start.
  always_comb begin
    stall_d = stall_q;
    if (state_q == FGAP && state_d == SEND)                  stall_d = '0;
    else if (tvalid_q && !M_AXIS_TREADY && (stall_q != '1)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) stall_q <= '0;
    else               stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TUSER  = tuser_q;
  assign frame_cnt     = frame_cnt_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_maxis_vpattern_gen.sv
// Scoreboard bench for maxis_vpattern_gen: expected beats queued per frame, popped on handshake.
module tb_maxis_vpattern_gen;

  localparam int unsigned DW = 32, BPP = 8, PH = 8, PV = 2, LG = 2, FG = 4, FCW = 2;

  logic           clk;
  logic           rst;
  logic           enable;
  logic [1:0]     mode;
  logic           tvalid;
  logic [DW-1:0]  tdata;
  logic [DW/8-1:0] tstrb;
  logic           tlast;
  logic           tuser;
  logic           tready;
  logic [FCW-1:0] frame_cnt;
  logic           frame_done;
  logic [31:0]    stall_cnt;

  maxis_vpattern_gen #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .BITS_PER_PIXEL      (BPP),
    .PIXELS_HORIZONTAL   (PH),
    .PIXELS_VERTICAL     (PV),
    .LINE_GAP            (LG),
    .FRAME_GAP           (FG),
    .FRAME_CNT_WIDTH     (FCW)
  ) dut (
    .M_AXIS_ACLK  (clk),
    .M_AXIS_ARESET(rst),
    .enable       (enable),
    .mode         (mode),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TDATA (tdata),
    .M_AXIS_TSTRB (tstrb),
    .M_AXIS_TLAST (tlast),
    .M_AXIS_TUSER (tuser),
    .M_AXIS_TREADY(tready),
    .frame_cnt    (frame_cnt),
    .frame_done   (frame_done),
    .stall_cnt    (stall_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        user;
    logic        eof;
  } beat_t;

  beat_t       exp_q[$];
  int          n_checks;
  int          n_fail;
  int          ready_mode;   // 0: always ready, 1: random, 2: never ready
  int          stall_seen;
  logic        stall_pend;
  logic [33:0] held;
  logic        fd_exp;
  logic        in_lgap;
  int          lgap_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int m, input int x, input int y, input int fc);
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      int p;
      int v;
      p = x + i;
      case (m)
        0:       v = (p + y + fc) % 256;
        1:       v = (((p * 8) / PH) * 32) % 256;
        2:       v = ((((p / 8) ^ (y / 8)) % 2) == 1) ? 255 : 0;
        default: v = 255;
      endcase
      d[i*8 +: 8] = 8'(v);
    end
    return d;
  endfunction

  task automatic push_frame(input int m, input int fc);
    for (int y = 0; y < PV; y++) begin
      for (int x = 0; x < PH; x += 4) begin
        beat_t b;
        b.data = exp_data(m, x, y, fc);
        b.last = (x == PH - 4);
        b.user = (x == 0) && (y == 0);
        b.eof  = b.last && (y == PV - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // TREADY driver, changes just after each rising edge.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      tready = 1'b1;
      else if (ready_mode == 1) tready = 1'($urandom_range(0, 1));
      else                      tready = 1'b0;
    end
  end

  // Monitor: scoreboard pop, stall stability, line gap and frame_done timing.
  initial begin
    stall_pend = 1'b0;
    fd_exp     = 1'b0;
    in_lgap    = 1'b0;
    lgap_n     = 0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pend = 1'b0;
        fd_exp     = 1'b0;
        in_lgap    = 1'b0;
      end else begin
        check_eq("frame_done", 64'(frame_done), 64'(fd_exp));
        fd_exp = 1'b0;
        if (stall_pend)
          check_eq("stall_hold", 64'({tvalid, tdata, tlast, tuser}), 64'({1'b1, held}));
        stall_pend = 1'b0;
        if (in_lgap) begin
          if (tvalid) begin
            check_eq("line_gap", 64'(lgap_n), 64'(LG));
            in_lgap = 1'b0;
          end else begin
            lgap_n++;
          end
        end
        if (tvalid && !tready) begin
          stall_pend = 1'b1;
          held       = {tdata, tlast, tuser};
          stall_seen++;
        end
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 64'(exp_q.size()), 64'(1));
          end else begin
            beat_t b;
            b = exp_q.pop_front();
            check_eq("beat", 64'({tdata, tlast, tuser}), 64'({b.data, b.last, b.user}));
            if (b.eof) fd_exp = 1'b1;
            else if (b.last) begin
              in_lgap = 1'b1;
              lgap_n  = 0;
            end
          end
        end
      end
    end
  end

  task automatic wait_valid(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tvalid && n < budget);
    check_eq(tag, 64'(tvalid), 64'(1));
  endtask

  task automatic wait_frame_done(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < budget);
    check_eq(tag, 64'(frame_done), 64'(1));
  endtask

  task automatic check_idle(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (tvalid) seen = 1'b1;
    end
    check_eq(tag, 64'(seen), 64'(0));
  endtask

  initial begin
    int n;
    n_checks   = 0;
    n_fail     = 0;
    stall_seen = 0;
    ready_mode = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    mode       = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_tvalid", 64'(tvalid), 64'(0));
    check_eq("rst_tdata", 64'(tdata), 64'(0));
    check_eq("rst_tlast_tuser", 64'({tlast, tuser}), 64'(0));
    check_eq("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check_eq("rst_frame_done", 64'(frame_done), 64'(0));
    check_eq("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    check_eq("tstrb", 64'(tstrb), 64'(4'hF));

    // Counter frame, always ready; enable dropped during line 0.
    push_frame(0, 0);
    enable = 1'b1;
    wait_valid("s1_start", 50, n);
    // n counts the enable-sampling edge plus FRAME_GAP+1 further edges.
    check_eq("s1_latency", 64'(n), 64'(1 + 1 + FG));
    check_eq("s1_first", 64'({tdata, tuser}), 64'({32'h03020100, 1'b1}));
    enable = 1'b0;
    wait_frame_done("s1_done", 100);
    check_eq("s1_frame_cnt", 64'(frame_cnt), 64'(1));
    check_idle("s1_idle", 20);
    check_eq("s1_drain", 64'(exp_q.size()), 64'(0));

    // Random backpressure, second frame (frame_cnt=1 offset).
    ready_mode = 1;
    stall_seen = 0;
    push_frame(0, 1);
    enable = 1'b1;
    wait_valid("s2_start", 50, n);
    enable = 1'b0;
    wait_frame_done("s2_done", 300);
`ifdef MAXIS_VPG_STALL_CNT_EN
    check_eq("s2_stall_cnt", 64'(stall_cnt), 64'(stall_seen));
`else
    check_eq("s2_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    check_eq("s2_frame_cnt", 64'(frame_cnt), 64'(2));
    check_eq("s2_drain", 64'(exp_q.size()), 64'(0));
    ready_mode = 0;

    // Bars latched, mode switched mid-frame; next frame checker; counter wraps.
    mode = 2'd1;
    push_frame(1, 2);
    enable = 1'b1;
    wait_valid("s4_start", 50, n);
    mode = 2'd2;
    push_frame(2, 3);
    wait_frame_done("s4_done_a", 100);
    check_eq("s4_frame_cnt", 64'(frame_cnt), 64'(3));
    wait_valid("s4_start_b", 50, n);
    enable = 1'b0;
    wait_frame_done("s4_done_b", 100);
    check_eq("s6_wrap", 64'(frame_cnt), 64'(0));
    check_eq("s4_drain", 64'(exp_q.size()), 64'(0));
    check_idle("s4_idle", 20);

    // Reset while a beat is stalled.
    ready_mode = 2;
    mode       = 2'd0;
    push_frame(0, 0);
    enable = 1'b1;
    wait_valid("s5_start", 50, n);
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    check_eq("s5_rst_tvalid", 64'(tvalid), 64'(0));
    check_eq("s5_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check_eq("s5_rst_out", 64'({tdata, tlast, tuser}), 64'(0));
    rst = 1'b0;
    exp_q.delete();
    ready_mode = 0;
    push_frame(0, 0);
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    wait_valid("s5_restart", 50, n);
    check_eq("s5_first", 64'({tdata, tuser}), 64'({32'h03020100, 1'b1}));
    enable = 1'b0;
    wait_frame_done("s5_done", 100);
    check_eq("s5_frame_cnt", 64'(frame_cnt), 64'(1));
    check_eq("s5_drain", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
